// File: rtl/simple_serial_arbiter.sv
// rtl/simple_serial_arbiter.sv - round-robin arbiter/sequencer sharing one serial shift engine
//
// Grants one requester at a time onto a shared serial engine, launches the
// transfer, applies an optional completion timeout (aborting the engine when
// it expires) and returns read data / error status to the owner.
//
// Ports:
//   axi_clk, axi_rst           clock, synchronous active-high reset
//   req                        per-requester request level, held until ack
//   req_wdata, req_len         packed per-requester data and bit count
//   timeout_cycles             completion timeout in WAIT cycles, 0 = off
//   ack                        one-hot one-cycle completion pulse
//   rsp_rdata, rsp_err         response payload, valid with ack
//   ser_start, ser_abort       one-cycle launch / abort pulses to the engine
//   ser_wdata, ser_len         transfer parameters, stable for the transfer
//   ser_busy, ser_done         engine status / completion pulse
//   ser_rdata                  engine read data, valid with ser_done
//   cur_owner                  current or most recent grantee
//   busy                       arbiter not idle
module simple_serial_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 6,
    parameter int TIMEOUT_W = 16,
    parameter int OWN_W     = $clog2(N_REQ)
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    input  logic [TIMEOUT_W-1:0]      timeout_cycles,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      ser_start,
    output logic [DATA_W-1:0]         ser_wdata,
    output logic [LEN_W-1:0]          ser_len,
    output logic                      ser_abort,
    input  logic                      ser_busy,
    input  logic                      ser_done,
    input  logic [DATA_W-1:0]         ser_rdata,
    output logic [OWN_W-1:0]          cur_owner,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ABORT,
        S_RESP
    } state_t;

    state_t               state, state_n;
    logic [OWN_W-1:0]     rr_ptr, rr_ptr_n;
    logic [TIMEOUT_W-1:0] tmr, tmr_n;

    logic [N_REQ-1:0]     ack_n;
    logic [DATA_W-1:0]    rsp_rdata_n;
    logic                 rsp_err_n;
    logic                 ser_start_n;
    logic [DATA_W-1:0]    ser_wdata_n;
    logic [LEN_W-1:0]     ser_len_n;
    logic                 ser_abort_n;
    logic [OWN_W-1:0]     cur_owner_n;

    logic [DATA_W-1:0]    wdata_arr [N_REQ];
    logic [LEN_W-1:0]     len_arr   [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
        assign len_arr[g]   = req_len[g*LEN_W +: LEN_W];
    end

    // Round-robin search: first asserted req at or above rr_ptr, wrapping.
    logic             found;
    logic [OWN_W-1:0] winner;
    logic [OWN_W-1:0] cand;
    int               scan_idx;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        scan_idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % N_REQ;
            cand     = OWN_W'(scan_idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    logic [LEN_W-1:0] win_len;
    logic             len_bad;
    logic             timeout_hit;
    logic [N_REQ-1:0] owner_onehot;

    assign win_len      = len_arr[winner];
    assign len_bad      = (win_len == '0) || (32'(win_len) > 32'(DATA_W));
    assign timeout_hit  = (timeout_cycles != '0) &&
                          (tmr == timeout_cycles - TIMEOUT_W'(1));
    assign owner_onehot = N_REQ'(1) << cur_owner;

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        tmr_n       = tmr;
        ack_n       = '0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        ser_start_n = 1'b0;
        ser_wdata_n = ser_wdata;
        ser_len_n   = ser_len;
        ser_abort_n = 1'b0;
        cur_owner_n = cur_owner;

        case (state)
            S_IDLE: begin
                if (found) begin
                    cur_owner_n = winner;
                    ser_wdata_n = wdata_arr[winner];
                    ser_len_n   = win_len;
                    rr_ptr_n    = (winner == OWN_W'(N_REQ - 1)) ? '0 : winner + OWN_W'(1);
                    if (len_bad) begin
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                        state_n     = S_RESP;
                    end else begin
                        // Launch straight away when the engine is free so the
                        // start pulse coincides with the first LAUNCH cycle.
                        ser_start_n = !ser_busy;
                        state_n     = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                tmr_n = '0;
                if (ser_start) begin
                    state_n = S_WAIT;
                end else if (!ser_busy) begin
                    ser_start_n = 1'b1;
                end
            end

            S_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (ser_done) begin
                    rsp_rdata_n = ser_rdata;
                    rsp_err_n   = 1'b0;
                    ack_n       = owner_onehot;
                    state_n     = S_RESP;
                end else if (timeout_hit) begin
                    ser_abort_n = 1'b1;
                    state_n     = S_ABORT;
                end else begin
                    tmr_n = tmr + TIMEOUT_W'(1);
                end
            end

            S_ABORT: begin
                if (!ser_busy) begin
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    ack_n       = owner_onehot;
                    state_n     = S_RESP;
                end
            end

            S_RESP: begin
                // Engine completions enter RESP with ack already raised; the
                // length-error path arrives without it and raises it here.
                if (ack != '0) begin
                    state_n = S_IDLE;
                end else begin
                    ack_n = owner_onehot;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            tmr       <= '0;
            ack       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ser_start <= 1'b0;
            ser_wdata <= '0;
            ser_len   <= '0;
            ser_abort <= 1'b0;
            cur_owner <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            tmr       <= tmr_n;
            ack       <= ack_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            ser_start <= ser_start_n;
            ser_wdata <= ser_wdata_n;
            ser_len   <= ser_len_n;
            ser_abort <= ser_abort_n;
            cur_owner <= cur_owner_n;
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_simple_serial_arbiter.sv
// tb/tb_simple_serial_arbiter.sv - scoreboard bench for simple_serial_arbiter
module tb_simple_serial_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 6;
    localparam int TIMEOUT_W = 16;
    localparam int OWN_W     = 2;

    logic                    axi_clk = 1'b0;
    logic                    axi_rst = 1'b1;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_wdata = '0;
    logic [N_REQ*LEN_W-1:0]  req_len = '0;
    logic [TIMEOUT_W-1:0]    timeout_cycles = '0;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    ser_start;
    logic [DATA_W-1:0]       ser_wdata;
    logic [LEN_W-1:0]        ser_len;
    logic                    ser_abort;
    logic                    ser_busy = 1'b0;
    logic                    ser_done = 1'b0;
    logic [DATA_W-1:0]       ser_rdata = '0;
    logic [OWN_W-1:0]        cur_owner;
    logic                    busy;

    simple_serial_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst), .req(req), .req_wdata(req_wdata),
        .req_len(req_len), .timeout_cycles(timeout_cycles), .ack(ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ser_start(ser_start),
        .ser_wdata(ser_wdata), .ser_len(ser_len), .ser_abort(ser_abort),
        .ser_busy(ser_busy), .ser_done(ser_done), .ser_rdata(ser_rdata),
        .cur_owner(cur_owner), .busy(busy)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},       32'(ack), 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err), 32'h0);
        check({tag, "_ser_start"}, 32'(ser_start), 32'h0);
        check({tag, "_ser_wdata"}, ser_wdata, 32'h0);
        check({tag, "_ser_len"},   32'(ser_len), 32'h0);
        check({tag, "_ser_abort"}, 32'(ser_abort), 32'h0);
        check({tag, "_cur_owner"}, 32'(cur_owner), 32'h0);
        check({tag, "_busy"},      32'(busy), 32'h0);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [5:0] l);
        req_wdata[i*DATA_W +: DATA_W] = d;
        req_len[i*LEN_W +: LEN_W]     = l;
        req[i]                        = 1'b1;
    endtask

    // Scoreboard entries
    typedef struct {
        int          cyc;
        logic [3:0]  ack;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
    } ack_t;

    typedef struct {
        int          cyc;
        logic [1:0]  owner;
        logic [5:0]  len;
        logic [31:0] wdata;
    } start_t;

    ack_t   ack_q[$];
    start_t start_q[$];
    int     abort_q[$];
    int     abort_seen = 0;

    // Engine model
    typedef enum int {E_IDLE, E_RUN, E_HOLD} eng_t;
    eng_t        e_state = E_IDLE;
    int          e_cnt = 0;
    int          eng_lat = 3;
    bit          eng_never = 1'b0;
    logic [31:0] eng_key = 32'h0;
    int          abort_hold = 3;
    int          busy_until = 0;

    initial forever begin
        @(negedge axi_clk);
        ser_done = 1'b0;
        if (axi_rst) begin
            e_state  = E_IDLE;
            ser_busy = (cyc < busy_until);
        end else begin
            case (e_state)
                E_IDLE: begin
                    if (ser_start) begin
                        ser_busy = 1'b1;
                        e_cnt    = 1;
                        e_state  = E_RUN;
                    end else begin
                        ser_busy = (cyc < busy_until);
                    end
                end
                E_RUN: begin
                    if (ser_abort) begin
                        e_cnt   = 0;
                        e_state = E_HOLD;
                    end else if (!eng_never && e_cnt == eng_lat) begin
                        ser_done  = 1'b1;
                        ser_rdata = ser_wdata ^ eng_key;
                        ser_busy  = 1'b0;
                        e_state   = E_IDLE;
                    end else begin
                        e_cnt++;
                    end
                end
                E_HOLD: begin
                    e_cnt++;
                    if (e_cnt > abort_hold) begin
                        ser_busy = 1'b0;
                        e_state  = E_IDLE;
                    end
                end
                default: e_state = E_IDLE;
            endcase
        end
    end

    // Monitor
    initial forever begin
        @(negedge axi_clk);
        if (ack != '0) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'h0);
            end else begin
                ack_t e;
                e = ack_q.pop_front();
                check("ack_value", 32'(ack), 32'(e.ack));
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                check("rsp_err",   32'(rsp_err), 32'(e.err));
                if (e.chk_rdata) check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
        if (ser_start) begin
            if (start_q.size() == 0) begin
                check("unexpected_start", 32'(ser_start), 32'h0);
            end else begin
                start_t s;
                s = start_q.pop_front();
                check("start_cycle", 32'(cyc), 32'(s.cyc));
                check("cur_owner",   32'(cur_owner), 32'(s.owner));
                check("ser_len",     32'(ser_len), 32'(s.len));
                check("ser_wdata",   ser_wdata, s.wdata);
            end
        end
        if (ser_abort) begin
            abort_seen++;
            if (abort_q.size() == 0) begin
                check("unexpected_abort", 32'(ser_abort), 32'h0);
            end else begin
                int a;
                a = abort_q.pop_front();
                check("abort_cycle", 32'(cyc), 32'(a));
            end
        end
    end

    initial begin
        int r;
        int t;
        int n_ab;

        // Fairness: all requests held from reset.
        eng_lat = 3;
        eng_key = 32'hF0F0_0000;
        for (int i = 0; i < N_REQ; i++) set_req(i, 32'h1000 + 32'(i), 6'(i + 4));
        repeat (3) begin
            @(posedge axi_clk);
            #1;
        end
        @(negedge axi_clk);
        check_zero("reset");
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        r = cyc;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % 4;
            start_q.push_back('{r + 1 + 6*k, 2'(o), 6'(o + 4), 32'h1000 + 32'(o)});
            ack_q.push_back('{r + 5 + 6*k, 4'(1 << o), (32'h1000 + 32'(o)) ^ 32'hF0F0_0000, 1'b0, 1'b1});
        end
        go_to(r + 26);
        req = '0;
        go_to(r + 34);

        // Single request on requester 2.
        eng_lat = 10;
        eng_key = 32'h99;
        t = cyc;
        set_req(2, 32'hA5, 6'd8);
        start_q.push_back('{t + 1, 2'd2, 6'd8, 32'hA5});
        ack_q.push_back('{t + 12, 4'b0100, 32'h3C, 1'b0, 1'b1});
        go_to(t + 13);
        req[2] = 1'b0;
        go_to(t + 16);

        // Length errors: 0 and 33.
        t = cyc;
        set_req(1, 32'hDEAD, 6'd0);
        ack_q.push_back('{t + 2, 4'b0010, 32'h0, 1'b1, 1'b0});
        go_to(t + 3);
        req[1] = 1'b0;
        go_to(t + 6);
        t = cyc;
        set_req(1, 32'hBEEF, 6'd33);
        ack_q.push_back('{t + 2, 4'b0010, 32'h0, 1'b1, 1'b0});
        go_to(t + 3);
        req[1] = 1'b0;
        go_to(t + 6);

        // Timeout with T=5, engine never completes.
        timeout_cycles = 16'd5;
        eng_never      = 1'b1;
        t = cyc;
        set_req(3, 32'h1234, 6'd16);
        start_q.push_back('{t + 1, 2'd3, 6'd16, 32'h1234});
        abort_q.push_back(t + 7);
        ack_q.push_back('{t + 12, 4'b1000, 32'h0, 1'b1, 1'b1});
        go_to(t + 13);
        req[3] = 1'b0;
        go_to(t + 16);

        // Done coincides with the timeout cycle.
        eng_never = 1'b0;
        eng_lat   = 5;
        eng_key   = 32'hFF;
        t = cyc;
        set_req(0, 32'h55, 6'd8);
        start_q.push_back('{t + 1, 2'd0, 6'd8, 32'h55});
        ack_q.push_back('{t + 7, 4'b0001, 32'hAA, 1'b0, 1'b1});
        go_to(t + 8);
        req[0] = 1'b0;
        go_to(t + 11);

        // Timeout disabled: no abort for 1000 cycles.
        timeout_cycles = 16'd0;
        eng_never      = 1'b1;
        t = cyc;
        set_req(1, 32'h7, 6'd4);
        start_q.push_back('{t + 1, 2'd1, 6'd4, 32'h7});
        n_ab = abort_seen;
        go_to(t + 1002);
        check("no_abort_t0", 32'(abort_seen), 32'(n_ab));
        check("busy_t0", 32'(busy), 32'h1);
        axi_rst = 1'b1;
        req[1]  = 1'b0;
        t = cyc;
        go_to(t + 1);
        @(negedge axi_clk);
        check_zero("rst_t0");
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        go_to(cyc + 3);

        // Busy engine at grant, then reset in WAIT.
        t = cyc;
        busy_until = t + 4;
        set_req(2, 32'hC3, 6'd8);
        start_q.push_back('{t + 5, 2'd2, 6'd8, 32'hC3});
        go_to(t + 8);
        axi_rst = 1'b1;
        go_to(t + 9);
        @(negedge axi_clk);
        check_zero("rst_mid");
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        req[2]  = 1'b0;
        go_to(t + 30);
        check("busy_after_rst", 32'(busy), 32'h0);

        check("ack_q_empty",   32'(ack_q.size()), 32'h0);
        check("start_q_empty", 32'(start_q.size()), 32'h0);
        check("abort_q_empty", 32'(abort_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_serial_arbiter.md
# simple_serial_arbiter

Round-robin transaction arbiter and sequencer that shares one simple-serial shift engine between `N_REQ` requesters. It sits in the `axi_clk` domain between the AXI-facing register blocks and the serial engine. It does four things:
- accepts one transfer request per requester,
- launches it on the engine,
- enforces a completion timeout and aborts the engine when it expires,
- returns read data and status to the owning requester.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: transfer data width.
- `LEN_W`, 6: width of the bit-count field.
- `TIMEOUT_W`, 16: width of the timeout counter.
- `OWN_W`, `$clog2(N_REQ)`: derived; width of the owner index.

Ports:
- `axi_clk` in 1: the only clock.
- `axi_rst` in 1: synchronous, active-high reset.
- `req` in `N_REQ`: per-requester request level, held until that requester's `ack`.
- `req_wdata` in `N_REQ*DATA_W`: requester i's data is slice `[i*DATA_W +: DATA_W]`.
- `req_len` in `N_REQ*LEN_W`: bits to shift, 1..`DATA_W`; slice `[i*LEN_W +: LEN_W]`.
- `timeout_cycles` in `TIMEOUT_W`: static configuration; 0 disables the timeout.
- `ack` out `N_REQ`: one-hot, one-cycle completion pulse.
- `rsp_rdata` out `DATA_W`: captured read data; valid while `ack` is nonzero.
- `rsp_err` out 1: error flag; valid while `ack` is nonzero.
- `ser_start` out 1: one-cycle launch pulse to the engine.
- `ser_wdata` out `DATA_W`: data to the engine; stable from `ser_start` until completion.
- `ser_len` out `LEN_W`: bit count to the engine; stable from `ser_start` until completion.
- `ser_abort` out 1: one-cycle abort pulse to the engine.
- `ser_busy` in 1: engine is shifting or recovering.
- `ser_done` in 1: one-cycle pulse; the engine's transfer is complete.
- `ser_rdata` in `DATA_W`: engine read data; valid with `ser_done`.
- `cur_owner` out `OWN_W`: index of the current or most recent grantee.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
States: IDLE, LAUNCH, WAIT, ABORT, RESP.

**IDLE**
- If any `req` bit is high, select the winner round-robin: search upward from `rr_ptr`, wrapping at `N_REQ`.
- Register the winner's index into `cur_owner`, and its data and length into `ser_wdata` and `ser_len`.
- Set `rr_ptr` = (winner+1) mod `N_REQ`.
- If the winner's length is 0 or greater than `DATA_W`, go to RESP with the error flag set and do not touch the engine.
- Otherwise go to LAUNCH.

**LAUNCH**
- While `ser_busy`=1, stay in LAUNCH and do not pulse `ser_start`.
- When `ser_busy`=0, assert `ser_start` for exactly one cycle and go to WAIT.
- Clear the timeout counter.

**WAIT**
- On `ser_done`: capture `ser_rdata`, set the error flag to 0, go to RESP.
- Otherwise, if `timeout_cycles`≠0 and the counter equals `timeout_cycles`−1: go to ABORT.
- Otherwise increment the counter.
- If `ser_done` and the timeout condition occur in the same cycle, `ser_done` wins.

**ABORT**
- Pulse `ser_abort` for one cycle on entry.
- Stay until `ser_busy`=0, then go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- A `ser_done` pulse arriving while in ABORT is ignored.

**RESP**
- Drive `ack[cur_owner]`=1 for one cycle together with `rsp_rdata` and `rsp_err`.
- Go to IDLE.

**Request rules**
- A requester must drop `req` at the clock edge where it samples its `ack` high. A `req` still high in the following IDLE cycle is treated as a new request.
- A request is sampled only in IDLE. Changes to `req_wdata` or `req_len` after the grant have no effect on the current transfer.

## Timing
**Reset values:** all outputs are 0, i.e. `ack`, `rsp_rdata`, `rsp_err`, `ser_start`, `ser_wdata`, `ser_len`, `ser_abort`, `cur_owner` and `busy`. Also `rr_ptr`=0, the timeout counter is 0, and the state is IDLE.

**Reset mid-transfer:** on the next edge the state returns to IDLE and no `ack` or `ser_abort` is issued. The engine is reset separately.

**Latency:**
- `req` high in IDLE at cycle t gives LAUNCH at t+1, with `ser_start` at t+1 if the engine is idle.
- `ser_done` at cycle d gives `ack` at d+1.
- A length-error request gives `ack` at t+2.

**Timeout:** with `timeout_cycles`=T, the abort occurs when no `ser_done` arrives within T WAIT cycles. `ser_abort` is asserted exactly T+1 cycles after `ser_start`.

**Outputs:** all outputs are registered. `busy` is 0 only in IDLE.

## Test plan
- Single request: `req[2]`, length 8, `wdata`=0xA5, engine returns 0x3C after 10 cycles. Expect one `ser_start` with `ser_len`=8, then `ack`=0b0100 one cycle after `ser_done` with `rsp_rdata`=0x3C and `rsp_err`=0.
- Fairness: all four `req` held continuously from reset, each re-raised after its ack. Grant order is 0,1,2,3,0, and `cur_owner` follows that order.
- Length errors: `req[1]` with length 0, and separately with length 33. Expect `ack[1]` and `rsp_err`=1 two cycles after the request, with no `ser_start` pulse.
- Timeout: `timeout_cycles`=5, engine never asserts `ser_done`, `ser_busy` is held for 3 cycles after the abort. Expect `ser_abort` 6 cycles after `ser_start`, then `ack` with `rsp_err`=1 once busy drops. Repeat with `timeout_cycles`=0 and expect no abort after 1000 cycles.
- Done/timeout collision: `ser_done` coincides with the timeout cycle. Expect no `ser_abort`, and `rsp_err`=0 with the captured data.
- Busy engine and reset: `ser_busy`=1 at grant, so `ser_start` is delayed until busy falls. Then assert `axi_rst` in WAIT; expect all outputs at 0 on the next edge and no `ack`.
